motion_alarm_ctrl: RTL and testbench

//  Consumes three PIR sensor readings (0..99 %), an enable ("turn") and an operator

---
 rtl/motion_alarm_ctrl.sv | 135 +++++++++++++
 tb/tb_motion_alarm_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/motion_alarm_ctrl.sv
// Motion alarm controller: per-sensor debounce, 2-of-3 / strong-reading trip,
// latched alarm with operator acknowledge and a cooldown before re-arming.
module motion_alarm_ctrl #(
  parameter int THRESHOLD      = 50,
  parameter int HIGH_THRESHOLD = 85,
  parameter int VOTES          = 2,
  parameter int DEBOUNCE       = 4,
  parameter int COOLDOWN       = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        turn,
  input  logic        stop_alarm,
  input  logic [6:0]  pir_sensor_1,
  input  logic [6:0]  pir_sensor_2,
  input  logic [6:0]  pir_sensor_3,
  output logic        alarm,
  output logic [1:0]  state,
  output logic [2:0]  qualified,
  output logic [2:0]  sensor_fault,
  output logic [15:0] motion_count
);

  localparam int              CD_W    = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [6:0]      TH_L    = 7'(THRESHOLD);
  localparam logic [6:0]      HI_L    = 7'(HIGH_THRESHOLD);
  localparam logic [6:0]      MAX_RD  = 7'd99;
  localparam logic [3:0]      DB_L    = 4'(DEBOUNCE);
  localparam logic [1:0]      VOTES_L = 2'(VOTES);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_ALARM = 2'd2,
    S_COOL  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            alarm_q, alarm_d;
  logic [CD_W-1:0] cd_q, cd_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [2:0][3:0] qcnt_q, qcnt_d;
  logic [2:0]      fault_q;

  logic [2:0][6:0] rd;
  logic [2:0]      hot, high, fault, qual;
  logic [1:0]      votes;
  logic            trip;
  logic            hold_clr;

  assign rd = {pir_sensor_3, pir_sensor_2, pir_sensor_1};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      fault[i] = rd[i] > MAX_RD;
      hot[i]   = (rd[i] >= TH_L) && !fault[i];
      high[i]  = rd[i] >= HI_L;
      qual[i]  = qcnt_q[i] == DB_L;
    end
    votes = 2'(qual[0]) + 2'(qual[1]) + 2'(qual[2]);
    trip  = (votes >= VOTES_L) || (|(qual & high));
  end

  // Debounce counters only run while the system is armed or alarming.
  always_comb begin
    hold_clr = !turn || (state_q == S_IDLE) || (state_q == S_COOL);
    for (int i = 0; i < 3; i++) begin
      qcnt_d[i] = '0;
      if (!hold_clr && hot[i]) begin
        qcnt_d[i] = (qcnt_q[i] == DB_L) ? DB_L : qcnt_q[i] + 4'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    alarm_d = alarm_q;
    cd_d    = cd_q;
    cnt_d   = cnt_q;
    if (!turn) begin
      state_d = S_IDLE;
      alarm_d = 1'b0;
      cd_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_ARMED;
        S_ARMED: begin
          if (trip) begin
            state_d = S_ALARM;
            alarm_d = 1'b1;
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          end
        end
        S_ALARM: begin
          if (stop_alarm) begin
            state_d = S_COOL;
            alarm_d = 1'b0;
            cd_d    = CD_LOAD;
          end
        end
        S_COOL: begin
          if (cd_q == '0) state_d = S_ARMED;
          else            cd_d    = cd_q - 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      alarm_q <= 1'b0;
      cd_q    <= '0;
      cnt_q   <= '0;
      qcnt_q  <= '0;
      fault_q <= '0;
    end else begin
      state_q <= state_d;
      alarm_q <= alarm_d;
      cd_q    <= cd_d;
      cnt_q   <= cnt_d;
      qcnt_q  <= qcnt_d;
      fault_q <= fault;
    end
  end

  assign alarm        = alarm_q;
  assign state        = state_q;
  assign qualified    = qual;
  assign sensor_fault = fault_q;
  assign motion_count = cnt_q;

endmodule

// File: tb/tb_motion_alarm_ctrl.sv
// Bench for motion_alarm_ctrl: directed scenarios plus randomized sensor traffic,
// all outputs compared every cycle against a streak-counting reference model.
module tb_motion_alarm_ctrl;

  localparam int TH   = 50;
  localparam int HI   = 85;
  localparam int NV   = 2;
  localparam int DEB  = 4;
  localparam int COOL = 256;

  logic        clk, rst_n, turn, stop_alarm;
  logic [6:0]  s1, s2, s3;
  logic        alarm;
  logic [1:0]  state;
  logic [2:0]  qualified, sensor_fault;
  logic [15:0] motion_count;

  motion_alarm_ctrl dut (
    .clk(clk), .rst_n(rst_n), .turn(turn), .stop_alarm(stop_alarm),
    .pir_sensor_1(s1), .pir_sensor_2(s2), .pir_sensor_3(s3),
    .alarm(alarm), .state(state), .qualified(qualified),
    .sensor_fault(sensor_fault), .motion_count(motion_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: mode 0..3, hot-streak length per sensor, cycles left in cooldown.
  int       m_mode, m_left, m_events;
  int       streak [3];
  bit       m_alarm;
  bit [2:0] m_fault;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit [2:0] m_qual();
    bit [2:0] q;
    for (int i = 0; i < 3; i++) q[i] = (streak[i] >= DEB);
    return q;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_events = 0; m_alarm = 0; m_fault = '0;
    for (int i = 0; i < 3; i++) streak[i] = 0;
  endtask

  task automatic model_step();
    int       r [3];
    bit [2:0] q;
    int       nq;
    bit       trip;
    r[0] = s1; r[1] = s2; r[2] = s3;
    q    = m_qual();
    nq   = int'(q[0]) + int'(q[1]) + int'(q[2]);
    trip = (nq >= NV);
    for (int i = 0; i < 3; i++) if (q[i] && r[i] >= HI) trip = 1;
    for (int i = 0; i < 3; i++) begin
      m_fault[i] = (r[i] > 99);
      if (!turn || m_mode == 0 || m_mode == 3) streak[i] = 0;
      else if (r[i] >= TH && r[i] <= 99)       streak[i] = (streak[i] < 1000) ? streak[i] + 1 : 1000;
      else                                     streak[i] = 0;
    end
    if (!turn) begin
      m_mode = 0; m_alarm = 0; m_left = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (trip) begin
        m_mode = 2; m_alarm = 1;
        if (m_events < 65535) m_events++;
      end
    end else if (m_mode == 2) begin
      if (stop_alarm) begin
        m_mode = 3; m_alarm = 0; m_left = COOL - 1;
      end
    end else begin
      if (m_left == 0) m_mode = 1;
      else             m_left--;
    end
  endtask

  task automatic check_all();
    check("state", 32'(state), 32'(m_mode));
    check("alarm", 32'(alarm), 32'(m_alarm));
    check("qualified", 32'(qualified), 32'(m_qual()));
    check("sensor_fault", 32'(sensor_fault), 32'(m_fault));
    check("motion_count", 32'(motion_count), 32'(m_events));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_rd(input int a, input int b, input int c);
    s1 = 7'(a); s2 = 7'(b); s3 = 7'(c);
  endtask

  task automatic drive_to_alarm();
    int n = 0;
    set_rd(90, 90, 90);
    while (alarm !== 1'b1 && n < 20) begin tick(); n++; end
    check("reach_alarm", 32'(alarm), 32'd1);
  endtask

  task automatic wait_armed();
    int n = 0;
    set_rd(0, 0, 0);
    stop_alarm = 1'b0;
    while (state !== 2'd1 && n < 400) begin tick(); n++; end
    check("reach_armed", 32'(state), 32'd1);
  endtask

  function automatic logic [6:0] pick();
    int k = $urandom_range(0, 9);
    if (k < 2)      return 7'($urandom_range(0, 49));
    else if (k < 6) return 7'($urandom_range(50, 84));
    else if (k < 9) return 7'($urandom_range(85, 99));
    else            return 7'($urandom_range(100, 127));
  endfunction

  initial begin
    int n;
    bit seen;
    rst_n = 1'b0; turn = 1'b0; stop_alarm = 1'b0;
    set_rd(0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    // Power up and arm.
    turn = 1'b1;
    tick();
    check("armed_after_turn", 32'(state), 32'd1);

    // Three hot sensors: alarm exactly DEB edges after the first hot edge.
    set_rd(69, 80, 62);
    tick();
    n = 0;
    while (alarm !== 1'b1 && n < 20) begin tick(); n++; end
    check("t1_latency", 32'(n), 32'(DEB));
    check("t1_count", 32'(motion_count), 32'd1);
    tick();
    check("t1_qualified", 32'(qualified), 32'b111);

    // Sensors dropped in ALARM: alarm holds; stop pulse starts a 256-cycle cooldown.
    set_rd(0, 0, 0);
    repeat (5) tick();
    check("t3_alarm_held", 32'(alarm), 32'd1);
    stop_alarm = 1'b1;
    tick();
    stop_alarm = 1'b0;
    check("t3_alarm_cleared", 32'(alarm), 32'd0);
    n = 1;
    while (state === 2'd3 && n < 400) begin tick(); n++; end
    check("t3_cool_len", 32'(n - 1), 32'(COOL));
    check("t3_rearmed", 32'(state), 32'd1);

    // Only one qualified sensor below the strong threshold: no alarm.
    set_rd(30, 51, 30);
    repeat (50) tick();
    check("t2_qual", 32'(qualified), 32'b010);
    check("t2_no_alarm", 32'(alarm), 32'd0);
    set_rd(30, 90, 30);
    seen = 0;
    for (int i = 0; i < DEB; i++) begin tick(); if (alarm === 1'b1) seen = 1; end
    check("t2_strong_trip", 32'(seen), 32'd1);
    stop_alarm = 1'b1; tick(); stop_alarm = 1'b0;
    wait_armed();

    // Hot for DEB-1 cycles then cold: never qualifies.
    for (int r = 0; r < 10; r++) begin
      set_rd(70, 70, 70);
      repeat (DEB - 1) tick();
      set_rd(0, 0, 0);
      tick();
    end
    check("t4_no_alarm", 32'(alarm), 32'd0);

    // Faulty sensor 1 plus a moderate sensor 3: fault flagged, no trip.
    set_rd(120, 0, 80);
    repeat (20) tick();
    check("t5_fault", 32'(sensor_fault), 32'b001);
    check("t5_no_alarm", 32'(alarm), 32'd0);

    // turn=0 in ALARM and in COOLDOWN.
    drive_to_alarm();
    turn = 1'b0; tick();
    check("t6_idle_from_alarm", 32'(state), 32'd0);
    turn = 1'b1; tick();
    drive_to_alarm();
    stop_alarm = 1'b1; tick(); stop_alarm = 1'b0;
    repeat (10) tick();
    turn = 1'b0; tick();
    check("t6_idle_from_cool", 32'(state), 32'd0);
    turn = 1'b1; tick();

    // Asynchronous reset in the middle of an alarm.
    drive_to_alarm();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_alarm", 32'(alarm), 32'd0);
    check("t6_async_count", 32'(motion_count), 32'd0);
    model_reset();
    rst_n = 1'b1;
    tick();

    // Randomized traffic.
    for (int seg = 0; seg < 500; seg++) begin
      int len;
      s1 = pick(); s2 = pick(); s3 = pick();
      turn = ($urandom_range(0, 49) != 0);
      len  = $urandom_range(1, 8);
      for (int c = 0; c < len; c++) begin
        stop_alarm = ($urandom_range(0, 15) == 0);
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
